receptor_teclado_ps2: RTL and testbench

PS/2 keyboard receiver that deserialises device frames into 8-bit scancodes and buffers them in a small FIFO. Sits directly upstream of the input multiplexer and drives its dado_lido_keyboard input. The processor pops one scancode per keyboard-read instruction with a one-cycle ler pulse. Sticky error flags report framing faults and overflow.

---
 rtl/receptor_teclado_ps2_if.sv | 42 ++++
 rtl/receptor_teclado_ps2.sv | 195 +++++++++++++++++++
 tb/tb_receptor_teclado_ps2.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/receptor_teclado_ps2_if.sv
`default_nettype none
// ============================================================================
//  Module      : receptor_teclado_ps2_if
//  Description : Consumer-side bus of the PS/2 keyboard receiver. The
//                controller pops scancodes with a one-cycle ler pulse and
//                clears the sticky error flags with limpar_erros.
//  Ports       : ler                 pop request (controller -> receiver)
//                limpar_erros        clear sticky flags (controller -> receiver)
//                dado_lido_keyboard  FIFO head scancode, 8'h00 when empty
//                tecla_disponivel    FIFO non-empty
//                erro_quadro         sticky framing/parity/timeout fault
//                erro_overflow       sticky dropped-frame flag
//  Modports    : master = controller side, slave = receiver side
//  Revision    : 1.0 - initial release
// ============================================================================
interface receptor_teclado_ps2_if;
    logic       ler;
    logic       limpar_erros;
    logic [7:0] dado_lido_keyboard;
    logic       tecla_disponivel;
    logic       erro_quadro;
    logic       erro_overflow;

    modport master (
        output ler,
        output limpar_erros,
        input  dado_lido_keyboard,
        input  tecla_disponivel,
        input  erro_quadro,
        input  erro_overflow
    );

    modport slave (
        input  ler,
        input  limpar_erros,
        output dado_lido_keyboard,
        output tecla_disponivel,
        output erro_quadro,
        output erro_overflow
    );
endinterface
`default_nettype wire

// File: rtl/receptor_teclado_ps2.sv
`default_nettype none
// ============================================================================
//  Module      : receptor_teclado_ps2
//  Description : PS/2 keyboard receiver. Deserialises 11-bit device frames
//                (start, 8 data LSB first, odd parity, stop) into scancodes
//                and buffers them in a small FIFO read by the processor.
//  Ports       : clock     system clock, rising edge
//                reset_n   asynchronous active-low reset
//                ps2_clk   raw PS/2 clock line (asynchronous)
//                ps2_data  raw PS/2 data line (asynchronous)
//                bus       receptor_teclado_ps2_if.slave (pop/clear/status)
//  Options     : KEYBOARD_BREAK_FILTER_EN - when defined, break prefixes
//                (8'hF0) and the byte following them are dropped so only
//                make codes are queued.
//  Revision    : 1.0 - initial release
// ============================================================================
module receptor_teclado_ps2 #(
    parameter int FIFO_PROFUNDIDADE = 4,
    parameter int TIMEOUT_CICLOS    = 50000
) (
    input  wire logic               clock,
    input  wire logic               reset_n,
    input  wire logic               ps2_clk,
    input  wire logic               ps2_data,
    receptor_teclado_ps2_if.slave   bus
);

    localparam int c_ptr_w = $clog2(FIFO_PROFUNDIDADE);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_to_w  = $clog2(TIMEOUT_CICLOS);
    localparam logic [c_to_w-1:0]  c_to_max = c_to_w'(TIMEOUT_CICLOS - 1);
    localparam logic [c_cnt_w-1:0] c_cheio  = c_cnt_w'(FIFO_PROFUNDIDADE);

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        RECEBENDO = 2'd1,
        VERIFICA  = 2'd2
    } estado_t;

    estado_t              r_estado;
    logic [3:0]           r_bits;
    logic [c_to_w-1:0]    r_timeout;
    logic [7:0]           r_shift;
    logic                 r_paridade;
    logic                 r_stop;

    logic                 r_clk_s1, r_clk_s2, r_clk_ant;
    logic                 r_data_s1, r_data_s2;

    logic [7:0]           r_mem [FIFO_PROFUNDIDADE];
    logic [c_ptr_w-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_erro_quadro, r_erro_overflow;

    logic w_queda, w_timeout, w_quadro_ok, w_push_req;
    logic w_cheia, w_vazia, w_push, w_pop;

    // Synchronisers reset to 1 so the idle-high line never looks like a fall.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_clk_ant <= 1'b1;
            r_data_s1 <= 1'b1;
            r_data_s2 <= 1'b1;
        end else begin
            r_clk_s1  <= ps2_clk;
            r_clk_s2  <= r_clk_s1;
            r_clk_ant <= r_clk_s2;
            r_data_s1 <= ps2_data;
            r_data_s2 <= r_data_s1;
        end
    end

    assign w_queda     = r_clk_ant & ~r_clk_s2;
    // A falling edge in the same cycle as expiry keeps the frame alive.
    assign w_timeout   = (r_estado == RECEBENDO) && !w_queda && (r_timeout == c_to_max);
    assign w_quadro_ok = (^{r_shift, r_paridade}) & r_stop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado   <= OCIOSO;
            r_bits     <= '0;
            r_timeout  <= '0;
            r_shift    <= '0;
            r_paridade <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    r_timeout <= '0;
                    if (w_queda && !r_data_s2) begin
                        r_estado <= RECEBENDO;
                        r_bits   <= '0;
                    end
                end
                RECEBENDO: begin
                    if (w_queda) begin
                        r_timeout <= '0;
                        r_bits    <= r_bits + 4'd1;
                        if (r_bits < 4'd8) begin
                            r_shift <= {r_data_s2, r_shift[7:1]};
                        end else if (r_bits == 4'd8) begin
                            r_paridade <= r_data_s2;
                        end else begin
                            r_stop   <= r_data_s2;
                            r_estado <= VERIFICA;
                        end
                    end else if (w_timeout) begin
                        r_timeout <= '0;
                        r_estado  <= OCIOSO;
                    end else begin
                        r_timeout <= r_timeout + c_to_w'(1);
                    end
                end
                VERIFICA: r_estado <= OCIOSO;
                default:  r_estado <= OCIOSO;
            endcase
        end
    end

`ifdef KEYBOARD_BREAK_FILTER_EN
    // Armed by a valid F0; the following valid byte (the released key) is
    // swallowed and disarms it. Bad frames and timeouts also disarm.
    logic r_descartar;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_descartar <= 1'b0;
        end else if (r_estado == VERIFICA) begin
            r_descartar <= w_quadro_ok && !r_descartar && (r_shift == 8'hF0);
        end else if (w_timeout) begin
            r_descartar <= 1'b0;
        end
    end

    assign w_push_req = (r_estado == VERIFICA) && w_quadro_ok &&
                        !r_descartar && (r_shift != 8'hF0);
`else
    assign w_push_req = (r_estado == VERIFICA) && w_quadro_ok;
`endif

    assign w_vazia = (r_count == '0);
    assign w_cheia = (r_count == c_cheio);
    assign w_pop   = bus.ler && !w_vazia;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = w_push_req && (!w_cheia || w_pop);

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flags: a new event outranks a simultaneous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_erro_quadro   <= 1'b0;
            r_erro_overflow <= 1'b0;
        end else begin
            if (w_timeout || ((r_estado == VERIFICA) && !w_quadro_ok))
                r_erro_quadro <= 1'b1;
            else if (bus.limpar_erros)
                r_erro_quadro <= 1'b0;

            if (w_push_req && w_cheia && !w_pop)
                r_erro_overflow <= 1'b1;
            else if (bus.limpar_erros)
                r_erro_overflow <= 1'b0;
        end
    end

    assign bus.dado_lido_keyboard = w_vazia ? 8'h00 : r_mem[r_rd_ptr];
    assign bus.tecla_disponivel   = !w_vazia;
    assign bus.erro_quadro        = r_erro_quadro;
    assign bus.erro_overflow      = r_erro_overflow;

endmodule
`default_nettype wire

// File: tb/tb_receptor_teclado_ps2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_receptor_teclado_ps2
//  Description : Self-checking bench for receptor_teclado_ps2. A queue holds
//                the scancodes the receiver should have buffered; each read
//                compares the FIFO head against the queue front. Honours
//                KEYBOARD_BREAK_FILTER_EN when defined for both builds.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_receptor_teclado_ps2;

    localparam int c_prof    = 4;
    localparam int c_timeout = 200;
    localparam int c_meio    = 5;

    logic clock = 1'b0;
    logic reset_n;
    logic ps2_clk;
    logic ps2_data;

    always #5 clock = ~clock;

    receptor_teclado_ps2_if bus ();

    receptor_teclado_ps2 #(
        .FIFO_PROFUNDIDADE (c_prof),
        .TIMEOUT_CICLOS    (c_timeout)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus.slave)
    );

    logic [7:0] q_esperado [$];
    bit exp_quadro, exp_over, exp_arm;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_checks++;
        if (obs === esp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, esp);
    endtask

    task automatic espera(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Sends bits[0..n-1]; optionally pulses ler in the receiver's check cycle
    // of the stop bit (3 clocks after the fall is driven).
    task automatic envia_bits(input logic [10:0] b, input int n, input bit ler_na_parada);
        for (int i = 0; i < n; i++) begin
            ps2_data = b[i];
            espera(c_meio);
            ps2_clk = 1'b0;
            if (ler_na_parada && i == 10) begin
                espera(3);
                bus.ler = 1'b1;
                espera(1);
                bus.ler = 1'b0;
                espera(c_meio - 4);
            end else begin
                espera(c_meio);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        espera(8);
    endtask

    task automatic modelo_push(input logic [7:0] d);
        if (q_esperado.size() < c_prof) q_esperado.push_back(d);
        else exp_over = 1'b1;
    endtask

    task automatic envia_quadro(input logic [7:0] d, input bit par_erro, input bit ler_junto);
        logic p;
        p = (~^d) ^ par_erro;
        envia_bits({1'b1, p, d, 1'b0}, 11, ler_junto);
        if (ler_junto && q_esperado.size() > 0) void'(q_esperado.pop_front());
        if (par_erro) begin
            exp_quadro = 1'b1;
            exp_arm    = 1'b0;
        end else begin
`ifdef KEYBOARD_BREAK_FILTER_EN
            if (exp_arm)            exp_arm = 1'b0;
            else if (d == 8'hF0)    exp_arm = 1'b1;
            else                    modelo_push(d);
`else
            modelo_push(d);
`endif
        end
    endtask

    task automatic le_tecla(input string tag);
        if (q_esperado.size() == 0) begin
            verifica({tag, "_disp"}, bus.tecla_disponivel, 0);
            verifica({tag, "_dado"}, bus.dado_lido_keyboard, 0);
        end else begin
            verifica({tag, "_disp"}, bus.tecla_disponivel, 1);
            verifica({tag, "_dado"}, bus.dado_lido_keyboard, q_esperado.pop_front());
        end
        bus.ler = 1'b1;
        espera(1);
        bus.ler = 1'b0;
        espera(1);
    endtask

    task automatic checa_flags(input string tag);
        verifica({tag, "_erro_quadro"},   bus.erro_quadro,   exp_quadro);
        verifica({tag, "_erro_overflow"}, bus.erro_overflow, exp_over);
    endtask

    task automatic checa_zero(input string tag);
        verifica({tag, "_disp"}, bus.tecla_disponivel, 0);
        verifica({tag, "_dado"}, bus.dado_lido_keyboard, 0);
        checa_flags(tag);
    endtask

    task automatic limpa;
        bus.limpar_erros = 1'b1;
        espera(1);
        bus.limpar_erros = 1'b0;
        exp_quadro = 1'b0;
        exp_over   = 1'b0;
        espera(1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] seq [5];
        seq = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        bus.ler = 1'b0;
        bus.limpar_erros = 1'b0;
        exp_quadro = 1'b0;
        exp_over = 1'b0;
        exp_arm = 1'b0;
        reset_n = 1'b0;
        espera(3);
        checa_zero("reset");
        reset_n = 1'b1;
        espera(2);

        // Single valid frame, read, then empty
        envia_quadro(8'h1C, 1'b0, 1'b0);
        le_tecla("t1_1c");
        le_tecla("t1_vazio");
        checa_flags("t1");

        // Parity error
        envia_quadro(8'h1C, 1'b1, 1'b0);
        checa_flags("t2_par");
        le_tecla("t2_vazio");
        limpa();
        checa_flags("t2_limpo");

        // Overflow: five frames into a four-deep FIFO
        foreach (seq[i]) envia_quadro(seq[i], 1'b0, 1'b0);
        checa_flags("t3_over");
        for (int i = 0; i < 5; i++) le_tecla("t3_le");
        limpa();

        // Timeout on a partial frame, then a clean frame
        envia_bits({7'h00, 4'b1010}, 4, 1'b0);
        espera(c_timeout + 20);
        exp_quadro = 1'b1;
        checa_flags("t4_timeout");
        envia_quadro(8'h2A, 1'b0, 1'b0);
        le_tecla("t4_2a");
        le_tecla("t4_vazio");
        limpa();

        // Full FIFO with simultaneous push and pop
        envia_quadro(8'h11, 1'b0, 1'b0);
        envia_quadro(8'h22, 1'b0, 1'b0);
        envia_quadro(8'h33, 1'b0, 1'b0);
        envia_quadro(8'h44, 1'b0, 1'b0);
        envia_quadro(8'h32, 1'b0, 1'b1);
        checa_flags("t5_sem_over");
        for (int i = 0; i < 5; i++) le_tecla("t5_le");

        // Break prefix handling
        envia_quadro(8'hF0, 1'b0, 1'b0);
        envia_quadro(8'h1C, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) le_tecla("t6_le");
        checa_flags("t6");

        // Reset mid-frame, then a clean frame
        envia_quadro(8'h3B, 1'b0, 1'b0);
        envia_bits({6'h00, 5'b10110}, 5, 1'b0);
        reset_n = 1'b0;
        q_esperado.delete();
        exp_quadro = 1'b0;
        exp_over = 1'b0;
        exp_arm = 1'b0;
        espera(2);
        checa_zero("t7_em_reset");
        reset_n = 1'b1;
        espera(2);
        checa_zero("t7_pos_reset");
        envia_quadro(8'h5A, 1'b0, 1'b0);
        le_tecla("t7_5a");
        le_tecla("t7_vazio");
        checa_flags("t7");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
